// File: rtl/vmem_leak_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmem_leak_pkg
// Brief    : Shared state encoding, Q-format defaults and saturation limits
//            for the membrane leak engine.
// Revision : 1.0
// ============================================================================
package vmem_leak_pkg;

    localparam int DEF_INTEGER_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH_FRAC = 32;
    localparam int DEF_DATA_WIDTH      = DEF_INTEGER_WIDTH + DEF_DATA_WIDTH_FRAC;
    localparam int DEF_DELTAT_WIDTH    = 4;
    localparam int DEF_NEURON_ID_WIDTH = 8;
    localparam int MAX_DATA_WIDTH      = 256;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Most positive (negative=0) or most negative (negative=1) value of a
    // width-bit two's-complement word, returned right-aligned.
    function automatic logic [MAX_DATA_WIDTH-1:0] sat_limit(input int width, input logic negative);
        logic [MAX_DATA_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < width - 1) begin
                v[i] = ~negative;
            end else if (i == width - 1) begin
                v[i] = negative;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_leak_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : vmem_leak_engine_if
// Brief    : Request/result handshake bundle of the membrane leak engine.
// Revision : 1.0
// ============================================================================
interface vmem_leak_engine_if import vmem_leak_pkg::*; #(
    parameter int INTEGER_WIDTH   = DEF_INTEGER_WIDTH,
    parameter int DATA_WIDTH_FRAC = DEF_DATA_WIDTH_FRAC,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = DEF_DELTAT_WIDTH,
    parameter int NEURON_ID_WIDTH = DEF_NEURON_ID_WIDTH
);
    logic                       InValid;
    logic                       InReady;
    logic [NEURON_ID_WIDTH-1:0] NeuronID;
    logic [INTEGER_WIDTH-1:0]   Vrest;
    logic [DATA_WIDTH-1:0]      Vmem;
    logic [DELTAT_WIDTH-1:0]    DeltaT;
    logic [INTEGER_WIDTH-1:0]   Taumem;
    logic                       OutValid;
    logic                       OutReady;
    logic [NEURON_ID_WIDTH-1:0] OutNeuronID;
    logic [DATA_WIDTH-1:0]      VmemOut;
    logic                       DivByZero;
    logic                       Saturated;

    modport slave (
        input  InValid, NeuronID, Vrest, Vmem, DeltaT, Taumem, OutReady,
        output InReady, OutValid, OutNeuronID, VmemOut, DivByZero, Saturated
    );

    modport master (
        output InValid, NeuronID, Vrest, Vmem, DeltaT, Taumem, OutReady,
        input  InReady, OutValid, OutNeuronID, VmemOut, DivByZero, Saturated
    );
endinterface
`default_nettype wire

// File: rtl/vmem_leak_engine_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_divider
// Brief    : Sign-magnitude restoring divider, one quotient bit per cycle,
//            truncating toward zero.
// Revision : 1.0
// ============================================================================
module seq_signed_divider #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      i_start,
    input  wire logic [DIVIDEND_WIDTH-1:0] i_dividend,
    input  wire logic [DIVISOR_WIDTH-1:0]  i_divisor,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [DIVIDEND_WIDTH-1:0]      o_quotient
);
    localparam int CNT_WIDTH = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

    logic                      r_busy_q, w_busy_d;
    logic [CNT_WIDTH-1:0]      r_cnt_q, w_cnt_d;
    logic [DIVIDEND_WIDTH-1:0] r_quo_q, w_quo_d;
    logic [DIVISOR_WIDTH-1:0]  r_rem_q, w_rem_d;
    logic [DIVISOR_WIDTH-1:0]  r_dsr_q, w_dsr_d;
    logic                      r_neg_q, w_neg_d;
    logic [DIVISOR_WIDTH:0]    w_shifted, w_diff;
    logic                      w_fits;

    // r_quo_q shifts the dividend magnitude out of its top while quotient
    // bits enter at the bottom.
    assign w_shifted = {r_rem_q, r_quo_q[DIVIDEND_WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, r_dsr_q});
    assign w_diff    = w_shifted - {1'b0, r_dsr_q};

    always_comb begin
        w_busy_d = r_busy_q;
        w_cnt_d  = r_cnt_q;
        w_quo_d  = r_quo_q;
        w_rem_d  = r_rem_q;
        w_dsr_d  = r_dsr_q;
        w_neg_d  = r_neg_q;
        if (i_start && !r_busy_q) begin
            w_busy_d = 1'b1;
            w_cnt_d  = '0;
            w_rem_d  = '0;
            w_quo_d  = i_dividend[DIVIDEND_WIDTH-1] ? -i_dividend : i_dividend;
            w_dsr_d  = i_divisor[DIVISOR_WIDTH-1] ? -i_divisor : i_divisor;
            w_neg_d  = i_dividend[DIVIDEND_WIDTH-1] ^ i_divisor[DIVISOR_WIDTH-1];
        end else if (r_busy_q) begin
            w_rem_d = w_fits ? DIVISOR_WIDTH'(w_diff) : DIVISOR_WIDTH'(w_shifted);
            w_quo_d = {r_quo_q[DIVIDEND_WIDTH-2:0], w_fits};
            w_cnt_d = r_cnt_q + 1'b1;
            if (r_cnt_q == C_LAST) begin
                w_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q <= 1'b0;
            r_cnt_q  <= '0;
            r_quo_q  <= '0;
            r_rem_q  <= '0;
            r_dsr_q  <= '0;
            r_neg_q  <= 1'b0;
        end else begin
            r_busy_q <= w_busy_d;
            r_cnt_q  <= w_cnt_d;
            r_quo_q  <= w_quo_d;
            r_rem_q  <= w_rem_d;
            r_dsr_q  <= w_dsr_d;
            r_neg_q  <= w_neg_d;
        end
    end

    // o_done marks the final iteration; o_quotient is valid from the next cycle.
    assign o_busy     = r_busy_q;
    assign o_done     = r_busy_q && (r_cnt_q == C_LAST);
    assign o_quotient = r_neg_q ? -r_quo_q : r_quo_q;

endmodule
`default_nettype wire

// File: rtl/vmem_leak_engine.sv
`default_nettype none
// ============================================================================
// Module   : vmem_leak_engine
// Brief    : Fixed-point membrane leak update
//            VmemOut = Vmem + ((Vrest<<FRAC) - Vmem) * DeltaT / Taumem.
// Revision : 1.0
// ============================================================================
module vmem_leak_engine import vmem_leak_pkg::*; #(
    parameter int INTEGER_WIDTH   = DEF_INTEGER_WIDTH,
    parameter int DATA_WIDTH_FRAC = DEF_DATA_WIDTH_FRAC,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = DEF_DELTAT_WIDTH,
    parameter int NEURON_ID_WIDTH = DEF_NEURON_ID_WIDTH,
    parameter int SATURATE        = 1
) (
    input wire logic          Clock,
    input wire logic          Reset,
    vmem_leak_engine_if.slave io_bus
);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int C_DT_SHIFT = DATA_WIDTH_FRAC - DELTAT_WIDTH;
    localparam logic [DATA_WIDTH-1:0] C_SAT_MAX = DATA_WIDTH'(sat_limit(DATA_WIDTH, 1'b0));
    localparam logic [DATA_WIDTH-1:0] C_SAT_MIN = DATA_WIDTH'(sat_limit(DATA_WIDTH, 1'b1));

    state_t                     r_state_q, w_state_d;
    logic [NEURON_ID_WIDTH-1:0] r_nid_q, w_nid_d;
    logic [INTEGER_WIDTH-1:0]   r_vrest_q, w_vrest_d;
    logic [INTEGER_WIDTH-1:0]   r_tau_q, w_tau_d;
    logic [DATA_WIDTH-1:0]      r_vmem_q, w_vmem_d;
    logic [DELTAT_WIDTH-1:0]    r_dt_q, w_dt_d;
    logic [DATA_WIDTH-1:0]      r_vmem_out_q, w_vmem_out_d;
    logic                       r_dbz_q, w_dbz_d;
    logic                       r_sat_q, w_sat_d;

    logic [DATA_WIDTH-1:0]        w_v1, w_dt_fx, w_prod, w_div_quot, w_quot, w_sum;
    logic signed [PROD_WIDTH-1:0] w_prod_full;
    logic                         w_tau_zero, w_div_start, w_div_busy, w_div_done, w_ovf;

    assign w_tau_zero  = (r_tau_q == '0);
    assign w_v1        = DATA_WIDTH'({r_vrest_q, {DATA_WIDTH_FRAC{1'b0}}}) - r_vmem_q;
    assign w_dt_fx     = DATA_WIDTH'(r_dt_q) << C_DT_SHIFT;
    assign w_prod_full = PROD_WIDTH'($signed(w_v1)) * PROD_WIDTH'($signed(w_dt_fx));
    assign w_prod      = DATA_WIDTH'(w_prod_full >>> DATA_WIDTH_FRAC);

    // The product is registered by the divider itself on the MULT edge.
    assign w_div_start = (r_state_q == MULT) && !w_tau_zero && !w_div_busy;

    seq_signed_divider #(
        .DIVIDEND_WIDTH (DATA_WIDTH),
        .DIVISOR_WIDTH  (INTEGER_WIDTH)
    ) u_divider (
        .clk        (Clock),
        .rst        (Reset),
        .i_start    (w_div_start),
        .i_dividend (w_prod),
        .i_divisor  (r_tau_q),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_div_quot)
    );

    assign w_quot = w_tau_zero ? '0 : w_div_quot;
    assign w_sum  = r_vmem_q + w_quot;
    assign w_ovf  = (r_vmem_q[DATA_WIDTH-1] == w_quot[DATA_WIDTH-1]) &&
                    (w_sum[DATA_WIDTH-1] != r_vmem_q[DATA_WIDTH-1]);

    always_comb begin
        w_state_d    = r_state_q;
        w_nid_d      = r_nid_q;
        w_vrest_d    = r_vrest_q;
        w_tau_d      = r_tau_q;
        w_vmem_d     = r_vmem_q;
        w_dt_d       = r_dt_q;
        w_vmem_out_d = r_vmem_out_q;
        w_dbz_d      = r_dbz_q;
        w_sat_d      = r_sat_q;
        case (r_state_q)
            IDLE: begin
                if (io_bus.InValid) begin
                    w_nid_d   = io_bus.NeuronID;
                    w_vrest_d = io_bus.Vrest;
                    w_tau_d   = io_bus.Taumem;
                    w_vmem_d  = io_bus.Vmem;
                    w_dt_d    = io_bus.DeltaT;
                    w_state_d = MULT;
                end
            end
            MULT: w_state_d = w_tau_zero ? ADD : DIV;
            DIV: begin
                if (w_div_done) begin
                    w_state_d = ADD;
                end
            end
            ADD: begin
                w_dbz_d = w_tau_zero;
                if (w_ovf && (SATURATE != 0)) begin
                    w_vmem_out_d = r_vmem_q[DATA_WIDTH-1] ? C_SAT_MIN : C_SAT_MAX;
                    w_sat_d      = 1'b1;
                end else begin
                    w_vmem_out_d = w_sum;
                    w_sat_d      = 1'b0;
                end
                w_state_d = DONE;
            end
            DONE: begin
                if (io_bus.OutReady) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state_q    <= IDLE;
            r_nid_q      <= '0;
            r_vrest_q    <= '0;
            r_tau_q      <= '0;
            r_vmem_q     <= '0;
            r_dt_q       <= '0;
            r_vmem_out_q <= '0;
            r_dbz_q      <= 1'b0;
            r_sat_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_nid_q      <= w_nid_d;
            r_vrest_q    <= w_vrest_d;
            r_tau_q      <= w_tau_d;
            r_vmem_q     <= w_vmem_d;
            r_dt_q       <= w_dt_d;
            r_vmem_out_q <= w_vmem_out_d;
            r_dbz_q      <= w_dbz_d;
            r_sat_q      <= w_sat_d;
        end
    end

    assign io_bus.InReady     = (r_state_q == IDLE);
    assign io_bus.OutValid    = (r_state_q == DONE);
    assign io_bus.OutNeuronID = r_nid_q;
    assign io_bus.VmemOut     = r_vmem_out_q;
    assign io_bus.DivByZero   = r_dbz_q;
    assign io_bus.Saturated   = r_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_vmem_leak_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vmem_leak_engine
// Brief    : Directed self-checking bench for vmem_leak_engine (clamping and
//            wrapping instances driven in lockstep).
// Revision : 1.0
// ============================================================================
module tb_vmem_leak_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  nid = '0;
    logic [31:0] vrest = '0;
    logic [63:0] vmem = '0;
    logic [3:0]  dt = '0;
    logic [31:0] tau = '0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vmem_leak_engine_if bus_sat ();
    vmem_leak_engine_if bus_wrap ();

    assign bus_sat.InValid   = in_valid;
    assign bus_sat.NeuronID  = nid;
    assign bus_sat.Vrest     = vrest;
    assign bus_sat.Vmem      = vmem;
    assign bus_sat.DeltaT    = dt;
    assign bus_sat.Taumem    = tau;
    assign bus_sat.OutReady  = out_ready;
    assign bus_wrap.InValid  = in_valid;
    assign bus_wrap.NeuronID = nid;
    assign bus_wrap.Vrest    = vrest;
    assign bus_wrap.Vmem     = vmem;
    assign bus_wrap.DeltaT   = dt;
    assign bus_wrap.Taumem   = tau;
    assign bus_wrap.OutReady = out_ready;

    vmem_leak_engine #(.SATURATE(1)) dut (
        .Clock  (clk),
        .Reset  (rst),
        .io_bus (bus_sat)
    );

    vmem_leak_engine #(.SATURATE(0)) dut_wrap (
        .Clock  (clk),
        .Reset  (rst),
        .io_bus (bus_wrap)
    );

    // Present a request, wait for the accept edge, then scramble the inputs.
    task automatic send_request(input logic [7:0] id, input logic [31:0] vr,
                                input logic [63:0] vm, input logic [3:0] d,
                                input logic [31:0] t);
        int waited;
        waited = 0;
        @(negedge clk);
        nid = id; vrest = vr; vmem = vm; dt = d; tau = t; in_valid = 1'b1;
        while (bus_sat.InReady !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        nid = 8'($urandom); vrest = $urandom; vmem = {$urandom, $urandom};
        dt = 4'($urandom); tau = $urandom;
    endtask

    // Edges counted with the accept edge as edge 1; leaves the bench at the
    // negedge where OutValid is first seen (200 means it never came).
    task automatic wait_result(output int edges);
        edges = 1;
        while (edges < 200) begin
            @(negedge clk);
            if (bus_sat.OutValid === 1'b1) break;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus_sat.OutValid, bus_sat.VmemOut, bus_sat.OutNeuronID, bus_sat.DivByZero, bus_sat.Saturated} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b vmem=%h id=%h dbz=%b sat=%b want all zero",
                     bus_sat.OutValid, bus_sat.VmemOut, bus_sat.OutNeuronID, bus_sat.DivByZero, bus_sat.Saturated);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus_sat.InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_inready: got %b want 1", bus_sat.InReady);
        end
    endtask

    // Full-latency request checked against hand-computed values on the clamping instance.
    task automatic test_leak(input string name, input logic [7:0] id, input logic [31:0] vr,
                             input logic [63:0] vm, input logic [3:0] d, input logic [31:0] t,
                             input logic [63:0] exp_vmem, input int exp_edges, input logic exp_dbz);
        int e;
        send_request(id, vr, vm, d, t);
        wait_result(e);
        n_cmp++;
        if (e !== exp_edges) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges want %0d", name, e, exp_edges);
        end
        n_cmp++;
        if (bus_sat.VmemOut !== exp_vmem) begin
            n_fail++;
            $display("FAIL %s_vmem: got %h want %h", name, bus_sat.VmemOut, exp_vmem);
        end
        n_cmp++;
        if ({bus_sat.OutNeuronID, bus_sat.DivByZero, bus_sat.Saturated} !== {id, exp_dbz, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_tag_flags: got id=%h dbz=%b sat=%b want id=%h dbz=%b sat=0",
                     name, bus_sat.OutNeuronID, bus_sat.DivByZero, bus_sat.Saturated, id, exp_dbz);
        end
        handshake();
    endtask

    task automatic test_saturation(input string name, input logic [31:0] vr, input logic [63:0] vm,
                                   input logic [31:0] t, input logic [63:0] exp_sat,
                                   input logic [63:0] exp_wrap);
        int e;
        send_request(8'h44, vr, vm, 4'd8, t);
        wait_result(e);
        n_cmp++;
        if ({bus_sat.VmemOut, bus_sat.Saturated} !== {exp_sat, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_clamp: got %h sat=%b want %h sat=1", name, bus_sat.VmemOut, bus_sat.Saturated, exp_sat);
        end
        n_cmp++;
        if ({bus_wrap.OutValid, bus_wrap.VmemOut, bus_wrap.Saturated} !== {1'b1, exp_wrap, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_wrap: got valid=%b %h sat=%b want valid=1 %h sat=0",
                     name, bus_wrap.OutValid, bus_wrap.VmemOut, bus_wrap.Saturated, exp_wrap);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int e;
        send_request(8'h66, 32'd10, 64'h0, 4'd8, 32'd5);
        wait_result(e);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; nid = 8'($urandom); vrest = $urandom;
            vmem = {$urandom, $urandom}; dt = 4'($urandom); tau = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({bus_sat.OutValid, bus_sat.InReady, bus_sat.VmemOut, bus_sat.OutNeuronID,
                 bus_sat.DivByZero, bus_sat.Saturated} !== {1'b1, 1'b0, 64'h0000_0001_0000_0000, 8'h66, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got valid=%b rdy=%b vmem=%h id=%h dbz=%b sat=%b want 1 0 0000000100000000 66 0 0",
                         i, bus_sat.OutValid, bus_sat.InReady, bus_sat.VmemOut, bus_sat.OutNeuronID,
                         bus_sat.DivByZero, bus_sat.Saturated);
            end
        end
        in_valid = 1'b0;
        handshake();
        @(negedge clk);
        n_cmp++;
        if ({bus_sat.InReady, bus_sat.OutValid} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_release: got rdy=%b valid=%b want rdy=1 valid=0", bus_sat.InReady, bus_sat.OutValid);
        end
    endtask

    task automatic test_reset_mid_div();
        int seen;
        seen = 0;
        send_request(8'h77, 32'd0, 64'h0000_0003_0000_0000, 4'd8, 32'd2);
        // Divider counter holds 20 after the 21st edge past accept.
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus_sat.InReady, bus_sat.OutValid} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_idle: got rdy=%b valid=%b want rdy=1 valid=0", bus_sat.InReady, bus_sat.OutValid);
        end
        repeat (80) begin
            @(negedge clk);
            if (bus_sat.OutValid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen);
        end
        test_leak("after_abort", 8'h5A, 32'd10, 64'h0, 4'd8, 32'd5, 64'h0000_0001_0000_0000, 67, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_leak("basic", 8'h11, 32'd10, 64'h0, 4'd8, 32'd5, 64'h0000_0001_0000_0000, 67, 1'b0);
        test_leak("decay", 8'h22, 32'd0, 64'h0000_0003_0000_0000, 4'd8, 32'd2, 64'h0000_0002_4000_0000, 67, 1'b0);
        test_leak("neg_tau", 8'h23, 32'd0, 64'h0000_0003_0000_0000, 4'd8, 32'hFFFF_FFFE, 64'h0000_0003_C000_0000, 67, 1'b0);
        test_leak("trunc_pos", 8'h24, 32'd1, 64'h0, 4'd1, 32'd3, 64'h0000_0000_0555_5555, 67, 1'b0);
        test_leak("trunc_neg", 8'h25, 32'hFFFF_FFFF, 64'h0, 4'd1, 32'd3, 64'hFFFF_FFFF_FAAA_AAAB, 67, 1'b0);
        test_leak("div_zero", 8'h33, 32'd7, 64'h0000_0005_8000_0000, 4'd15, 32'd0, 64'h0000_0005_8000_0000, 3, 1'b1);
        test_saturation("sat_neg", 32'd0, 64'h8000_0000_0000_0000, 32'd1,
                        64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
        test_saturation("sat_pos", 32'd0, 64'h7000_0000_0000_0000, 32'hFFFF_FFFF,
                        64'h7FFF_FFFF_FFFF_FFFF, 64'hA800_0000_0000_0000);
        test_backpressure();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vmem_leak_engine.md
VMEM_LEAK_ENGINE -- requirements
Module: vmem_leak_engine

Interface
REQ-001 The block SHALL have parameter INTEGER_WIDTH, default 32: integer bits of the fixed-point format.
REQ-002 The block SHALL have parameter DATA_WIDTH_FRAC, default 32: fraction bits of the fixed-point format.
REQ-003 The block SHALL have parameter DATA_WIDTH, default INTEGER_WIDTH+DATA_WIDTH_FRAC: membrane word width.
REQ-004 The block SHALL have parameter DELTAT_WIDTH, default 4: DeltaT width.
REQ-005 The block SHALL have parameter NEURON_ID_WIDTH, default 8: width of the pass-through tag.
REQ-006 The block SHALL have parameter SATURATE, default 1: 1 clamps the final sum, 0 wraps it.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset; its ports are Clock (in, 1, rising-edge clock) and Reset (in, 1, synchronous active-high reset).
REQ-008 Input ports (name  direction  width  meaning) SHALL be:
- InValid  in  1  request valid.
- InReady  out  1  block can accept a request.
- NeuronID  in  NEURON_ID_WIDTH  tag.
- Vrest  in  INTEGER_WIDTH  signed integer rest potential.
- Vmem  in  DATA_WIDTH  signed Q(INTEGER_WIDTH.DATA_WIDTH_FRAC) membrane potential.
- DeltaT  in  DELTAT_WIDTH  unsigned fraction, value DeltaT/2^DELTAT_WIDTH.
- Taumem  in  INTEGER_WIDTH  signed integer time constant.
REQ-009 Output ports (name  direction  width  meaning) SHALL be:
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- OutNeuronID  out  NEURON_ID_WIDTH  echoed tag.
- VmemOut  out  DATA_WIDTH  signed result, same Q format as Vmem.
- DivByZero  out  1  Taumem was 0 for this result.
- Saturated  out  1  the final sum was clamped.

Function
REQ-010 Accept SHALL occur on a rising edge with InValid=1 and InReady=1; all inputs SHALL be captured on that edge.
REQ-011 InReady SHALL be 1 only in state IDLE.
REQ-012 The block SHALL compute VmemOut = Vmem + ((Vrest<<DATA_WIDTH_FRAC) - Vmem) * DeltaT_frac / Taumem.
REQ-013 The subtraction V1 SHALL be DATA_WIDTH wide and wrap on overflow.
REQ-014 The product SHALL be the full 2*DATA_WIDTH result, truncated to bits [DATA_WIDTH+DATA_WIDTH_FRAC-1 : DATA_WIDTH_FRAC].
REQ-015 The quotient SHALL be an exact signed integer division of that product by Taumem, truncated toward zero, with the lower DATA_WIDTH bits kept.
REQ-016 The state machine SHALL have the following states and transitions:
- IDLE -> MULT on accept.
- MULT -> DIV when Taumem != 0; MULT -> ADD when Taumem = 0.
- DIV -> ADD after exactly DATA_WIDTH iterations.
- ADD -> DONE.
- DONE -> IDLE on OutValid & OutReady.
REQ-017 MULT SHALL register the product in one cycle.
REQ-018 DIV SHALL run a magnitude restoring divider at 1 quotient bit per cycle, using an iteration counter of 0..DATA_WIDTH-1, with sign = sign(product) XOR sign(Taumem).
REQ-019 Latency from the accept edge to OutValid SHALL be DATA_WIDTH+3 edges for Taumem != 0, and 3 edges for Taumem = 0.
REQ-020 With Taumem = 0, the quotient SHALL be forced to 0, VmemOut SHALL equal the captured Vmem, and DivByZero SHALL be 1.
REQ-021 With SATURATE=1, a signed overflow of the final add SHALL clamp VmemOut to 0x7FF..F or 0x800..0 and set Saturated=1; with SATURATE=0, the sum SHALL wrap and Saturated SHALL stay 0.
REQ-022 In DONE, OutValid SHALL be 1, and VmemOut, OutNeuronID and the flags SHALL be held stable until OutReady=1.
REQ-023 The block SHALL hold one request in flight; no new request SHALL be accepted until the DONE->IDLE transition, so InReady first rises on the edge after the output handshake.
REQ-024 Input changes while the block is not in IDLE SHALL have no effect.

Reset
REQ-025 Reset=1 on any edge SHALL force IDLE and abandon any in-flight operation.
REQ-026 During reset, OutValid, VmemOut, OutNeuronID, DivByZero, Saturated and the internal counter SHALL be cleared to 0.
REQ-027 InReady SHALL be 1 from the first edge after Reset deasserts.
REQ-028 An abandoned operation SHALL never produce OutValid.

Structure
REQ-029 Package vmem_leak_pkg SHALL hold the state enum (IDLE, MULT, DIV, ADD, DONE) and the Q-format width localparams and saturation constants.
REQ-030 The divider SHALL be sub-module seq_signed_divider, parameterised by dividend and divisor widths, with a start/busy/done interface and an iteration count equal to the dividend width.

Verification
REQ-031 Defaults, Vrest=10, Vmem=0, DeltaT=8, Taumem=5 -> VmemOut=0x0000_0001_0000_0000 (1.0), OutValid exactly 67 edges after accept, flags 0.
REQ-032 Vrest=0, Vmem=0x0000_0003_0000_0000, DeltaT=8, Taumem=2 -> VmemOut=0x0000_0002_4000_0000 (2.25).
REQ-033 Taumem=0, Vmem=0x0000_0005_8000_0000 -> VmemOut=0x0000_0005_8000_0000, DivByZero=1, OutValid 3 edges after accept.
REQ-034 Vrest=0, Vmem=0x8000_0000_0000_0000, DeltaT=8, Taumem=1 -> SATURATE=1: VmemOut=0x8000_0000_0000_0000 with Saturated=1; SATURATE=0: VmemOut=0x4000_0000_0000_0000 with Saturated=0.
REQ-035 Hold OutReady=0 for 10 cycles in DONE while toggling all inputs -> outputs stable and InReady=0; after the handshake, InReady=1 on the next edge.
REQ-036 Assert Reset for 1 cycle at DIV iteration 20 -> no OutValid; a following request with OutNeuronID=0x5A completes with correct values.
